// File: rtl/alu_pkg.sv
// Shared ALU definitions: serial adder state encoding and default width.
package alu_pkg;

   localparam int ALU_W = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_SHIFT = ST_SHIFT,
      S_DONE  = ST_DONE
   } sa_state_e;

endpackage

// File: rtl/half_adder.sv
// 1-bit half adder cell.
module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic c_out
);

   assign sum   = a ^ b;
   assign c_out = a & b;

endmodule

// File: rtl/serial_adder_full_adder.sv
// 1-bit full adder slice built from two half adders.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic c_out
);

   logic s0;
   logic c0;
   logic c1;

   half_adder u_ha0 (
      .a     (a),
      .b     (b),
      .sum   (s0),
      .c_out (c0)
   );

   half_adder u_ha1 (
      .a     (s0),
      .b     (c_in),
      .sum   (sum),
      .c_out (c1)
   );

   assign c_out = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder, LSB first, one full-adder slice.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
   import alu_pkg::*;
#(
   parameter int W = ALU_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         c_in,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
   output logic         ovf,
`endif
   output logic         c_out
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   sa_state_e    state_q, state_d;
   logic [W-1:0] a_sh_q, a_sh_d;
   logic [W-1:0] b_sh_q, b_sh_d;
   logic [W-1:0] sum_q, sum_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic         carry_q, carry_d;
   logic         c_out_q, c_out_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic         fa_s;
   logic         fa_co;

   full_adder u_fa (
      .a     (a_sh_q[0]),
      .b     (b_sh_q[0]),
      .c_in  (carry_q),
      .sum   (fa_s),
      .c_out (fa_co)
   );

`ifdef SERIAL_ADDER_OVF_EN
   logic ovf_q, ovf_d;
`endif

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      c_out_d = c_out_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = c_in;
               cnt_d   = '0;
               sum_d   = '0;
               busy_d  = 1'b1;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            sum_d   = {fa_s, sum_q[W-1:1]};
            carry_d = fa_co;
            cnt_d   = cnt_q + 1'b1;
            // Last bit: the slice is processing the MSB.
            if (cnt_q == CW'(W - 1)) begin
               c_out_d = fa_co;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d   = carry_q ^ fa_co;
`endif
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         c_out_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         c_out_q <= c_out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign sum   = sum_q;
   assign c_out = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (W=8 directed, W=8/13 random).
module tb_serial_adder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  a = '0;
   logic [7:0]  b = '0;
   logic        c_in = 1'b0;
   logic        busy;
   logic        done;
   logic [7:0]  sum;
   logic        c_out;
   logic        ovf;

   logic        start13 = 1'b0;
   logic [12:0] a13 = '0;
   logic [12:0] b13 = '0;
   logic        cin13 = 1'b0;
   logic        busy13;
   logic        done13;
   logic [12:0] sum13;
   logic        cout13;
`ifdef SERIAL_ADDER_OVF_EN
   logic        ovf13;
`endif

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   serial_adder #(.W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .c_in  (c_in),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
      .ovf   (ovf),
`endif
      .c_out (c_out)
   );

`ifndef SERIAL_ADDER_OVF_EN
   assign ovf = 1'b0;
`endif

   serial_adder #(.W(13)) dut13 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start13),
      .a     (a13),
      .b     (b13),
      .c_in  (cin13),
      .busy  (busy13),
      .done  (done13),
      .sum   (sum13),
`ifdef SERIAL_ADDER_OVF_EN
      .ovf   (ovf13),
`endif
      .c_out (cout13)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] s;
      logic       co;
      logic       ov;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_op(input vec_t v);
      int n;
      int bc;
      @(negedge clk);
      a = v.a;
      b = v.b;
      c_in = v.cin;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = ~v.a;
      b = ~v.b;
      bc = busy ? 1 : 0;
      n = 0;
      while (!done && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (busy) bc++;
      end
      chk("latency", n, 8);
      chk("busy_cycles", bc, 8);
      chk("busy_in_done", busy, 0);
      chk("sum", sum, v.s);
      chk("c_out", c_out, v.co);
`ifdef SERIAL_ADDER_OVF_EN
      chk("ovf", ovf, v.ov);
`endif
      @(posedge clk);
      #1;
      chk("done_pulse", done, 0);
      chk("sum_hold", sum, v.s);
   endtask

   initial begin
      vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
      vecs[3] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
      vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[5] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0};
      vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
      vecs[8] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[9] = '{8'h20, 8'h22, 1'b0, 8'h42, 1'b0, 1'b0};

      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", c_out, 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 10; i++) run_op(vecs[i]);

      // start held high: one acceptance per W+2 cycles, operands
      // scrambled while shifting
      begin
         int last;
         int nd;
         @(negedge clk);
         a = 8'h05;
         b = 8'h03;
         c_in = 1'b0;
         start = 1'b1;
         last = -1;
         nd = 0;
         for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk);
            #1;
            chk("busy_done_excl", busy & done, 0);
            if (busy) begin
               a = 8'hFF;
               b = 8'hFF;
               c_in = 1'b1;
            end
            if (done) begin
               chk("held_sum", sum, 8'h08);
               chk("held_cout", c_out, 0);
               if (last >= 0) chk("held_interval", cyc - last, 10);
               last = cyc;
               nd++;
               a = 8'h05;
               b = 8'h03;
               c_in = 1'b0;
            end
         end
         chk("held_done_count", nd >= 3, 1);
         start = 1'b0;
         repeat (12) @(posedge clk);
      end

      // async reset in the 4th SHIFT cycle
      @(negedge clk);
      a = 8'hFF;
      b = 8'hFF;
      c_in = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_sum", sum, 0);
      chk("arst_cout", c_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(vecs[9]);

      // random, both widths in lockstep
      for (int i = 0; i < 300; i++) begin
         logic [8:0]  e8;
         logic [13:0] e13;
         logic [8:0]  g8;
         logic [13:0] g13;
         bit          s8;
         bit          s13;
         int          n;
         @(negedge clk);
         a = 8'($urandom);
         b = 8'($urandom);
         c_in = 1'($urandom);
         a13 = 13'($urandom);
         b13 = 13'($urandom);
         cin13 = 1'($urandom);
         e8 = {1'b0, a} + {1'b0, b} + {8'd0, c_in};
         e13 = {1'b0, a13} + {1'b0, b13} + {13'd0, cin13};
         start = 1'b1;
         start13 = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         start13 = 1'b0;
         s8 = 0;
         s13 = 0;
         g8 = '0;
         g13 = '0;
         n = 0;
         while (!s13 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (done) begin
               s8 = 1;
               g8 = {c_out, sum};
            end
            if (done13) begin
               s13 = 1;
               g13 = {cout13, sum13};
            end
         end
         chk("rand8_seen", s8, 1);
         chk("rand13_seen", s13, 1);
         chk("rand8", g8, e8);
         chk("rand13", g13, e13);
         @(posedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
